// File: rtl/nibble_bank_loader.sv
// Fills an 8x4 nibble bank from a valid/ready stream or a patch port; bank updates 1 cycle after a beat/patch.
// Backpressure: o_in_ready is high only while filling. Optional checksum: NIBBLE_BANK_CHECKSUM_EN.
module nibble_bank_loader #(
  parameter int NIBBLE_W = 4,
  parameter int DEPTH    = 8
) (
  input  logic                       i_sysclk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_in_valid,
  input  logic [NIBBLE_W-1:0]        i_in_data,
  output logic                       o_in_ready,
  input  logic                       i_wr_en,
  input  logic [2:0]                 i_wr_addr,
  input  logic [NIBBLE_W-1:0]        i_wr_data,
  output logic                       o_wr_err,
  output logic [DEPTH*NIBBLE_W-1:0]  o_bank,
  output logic                       o_bank_valid,
  output logic [2:0]                 o_fill_ptr,
  output logic [NIBBLE_W-1:0]        o_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [DEPTH-1:0][NIBBLE_W-1:0]    r_bank;
  logic [2:0]                        r_fill_ptr;
  logic [2:0]                        w_fill_ptr_nxt;
  logic                              r_bank_valid;
  logic                              w_bank_valid_nxt;
  logic                              r_wr_err;
  logic                              w_wr_err_nxt;
  logic                              w_patch;
  logic                              w_beat;

  assign o_in_ready = (r_state == S_FILL);
  assign w_beat     = i_in_valid && o_in_ready;

  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_fill_ptr_nxt   = r_fill_ptr;
    w_bank_valid_nxt = r_bank_valid;
    w_wr_err_nxt     = 1'b0;
    w_patch          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_patch = i_wr_en;
        if (i_start) begin
          w_state_nxt      = S_FILL;
          w_fill_ptr_nxt   = 3'd0;
          w_bank_valid_nxt = 1'b0;
        end
      end
      S_FILL: begin
        w_wr_err_nxt = i_wr_en;
        if (w_beat) begin
          if (r_fill_ptr == 3'(DEPTH - 1)) begin
            w_state_nxt      = S_FULL;
            w_fill_ptr_nxt   = 3'd0;
            w_bank_valid_nxt = 1'b1;
          end else begin
            w_fill_ptr_nxt = r_fill_ptr + 3'd1;
          end
        end
        // abort wins over a completing beat: the beat is stored but the bank is not declared valid
        if (i_abort) begin
          w_state_nxt      = S_IDLE;
          w_fill_ptr_nxt   = 3'd0;
          w_bank_valid_nxt = 1'b0;
        end
      end
      S_FULL: begin
        w_patch = i_wr_en;
        if (i_start) begin
          w_state_nxt      = S_FILL;
          w_fill_ptr_nxt   = 3'd0;
          w_bank_valid_nxt = 1'b0;
        end else if (i_abort) begin
          w_state_nxt      = S_IDLE;
          w_bank_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_bank       <= '0;
      r_fill_ptr   <= 3'd0;
      r_bank_valid <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_fill_ptr   <= w_fill_ptr_nxt;
      r_bank_valid <= w_bank_valid_nxt;
      r_wr_err     <= w_wr_err_nxt;
      if (w_beat) begin
        r_bank[r_fill_ptr] <= i_in_data;
      end else if (w_patch) begin
        r_bank[i_wr_addr] <= i_wr_data;
      end
    end
  end

  assign o_bank       = r_bank;
  assign o_bank_valid = r_bank_valid;
  assign o_fill_ptr   = r_fill_ptr;
  assign o_wr_err     = r_wr_err;

`ifdef NIBBLE_BANK_CHECKSUM_EN
  logic [NIBBLE_W-1:0] w_sum;
  logic [NIBBLE_W-1:0] r_checksum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_sum = w_sum + r_bank[k];
    end
  end

  // trails the bank by one cycle, so it settles one cycle after any write
  always_ff @(posedge i_sysclk or posedge i_reset) begin
    if (i_reset) begin
      r_checksum <= '0;
    end else begin
      r_checksum <= w_sum;
    end
  end

  assign o_checksum = r_checksum;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_nibble_bank_loader.sv
// Directed and randomized bench for nibble_bank_loader against a slot-array reference model.
module tb_nibble_bank_loader;

  logic        sysclk = 1'b0;
  logic        reset, start, abort, in_valid, wr_en;
  logic [3:0]  in_data, wr_data;
  logic [2:0]  wr_addr;
  logic        in_ready, wr_err, bank_valid;
  logic [31:0] bank;
  logic [2:0]  fill_ptr;
  logic [3:0]  checksum;

  int checks   = 0;
  int failures = 0;

  // reference model: slot array, fill position, and two flags describing the mode
  logic [3:0] mbank [8];
  int         mptr;
  bit         mfill, mvalid, merr;
  logic [3:0] mck;

  nibble_bank_loader dut (
    .i_sysclk    (sysclk),
    .i_reset     (reset),
    .i_start     (start),
    .i_abort     (abort),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_wr_err    (wr_err),
    .o_bank      (bank),
    .o_bank_valid(bank_valid),
    .o_fill_ptr  (fill_ptr),
    .o_checksum  (checksum)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mflat();
    logic [31:0] r;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = mbank[k];
    return r;
  endfunction

  function automatic logic [3:0] msum();
    int s = 0;
    for (int k = 0; k < 8; k++) s += int'(mbank[k]);
    return 4'(s % 16);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) mbank[k] = 4'h0;
    mptr = 0; mfill = 0; mvalid = 0; merr = 0; mck = 4'h0;
  endtask

  task automatic model_edge();
    mck  = msum();
    merr = 0;
    if (mfill) begin
      if (wr_en) merr = 1;
      if (in_valid) begin
        mbank[mptr] = in_data;
        mptr++;
        if (mptr == 8) begin
          mptr = 0; mfill = 0; mvalid = 1;
        end
      end
      if (abort) begin
        mfill = 0; mptr = 0; mvalid = 0;
      end
    end else begin
      if (wr_en) mbank[wr_addr] = wr_data;
      if (start) begin
        mfill = 1; mptr = 0; mvalid = 0;
      end else if (abort) begin
        mvalid = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".bank"},       bank,       mflat());
    chk({tag, ".bank_valid"}, 32'(bank_valid), 32'(mvalid));
    chk({tag, ".fill_ptr"},   32'(fill_ptr),   32'(mptr));
    chk({tag, ".in_ready"},   32'(in_ready),   32'(mfill));
    chk({tag, ".wr_err"},     32'(wr_err),     32'(merr));
`ifdef NIBBLE_BANK_CHECKSUM_EN
    chk({tag, ".checksum"},   32'(checksum),   32'(mck));
`else
    chk({tag, ".checksum"},   32'(checksum),   32'h0);
`endif
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge sysclk);
    #1;
    start = 0; abort = 0; wr_en = 0;
    compare_all(tag);
  endtask

  initial begin
    int acc;
    logic [3:0] d;
    reset = 1; start = 0; abort = 0; in_valid = 0; in_data = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    model_reset();
    #1;
    compare_all("reset_async");
    @(posedge sysclk); #1;
    reset = 0;
    compare_all("reset_held");

    // 1: sequential fill 1..8
    start = 1; tick("t1_start");
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'(i + 1);
      tick("t1_beat");
    end
    in_valid = 0;
    chk("t1_bank", bank, 32'h87654321);
    chk("t1_valid", 32'(bank_valid), 32'h1);
    chk("t1_ready", 32'(in_ready), 32'h0);
    chk("t1_ptr", 32'(fill_ptr), 32'h0);
    tick("t1_idle");
`ifdef NIBBLE_BANK_CHECKSUM_EN
    chk("t1_checksum", 32'(checksum), 32'h4);
`endif

    // 2: in_valid toggled every other cycle
    start = 1; tick("t2_start");
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = in_valid ? 4'(i / 2 + 1) : 4'($urandom);
      if (in_valid && in_ready) acc++;
      tick("t2_beat");
    end
    in_valid = 0;
    chk("t2_accepted", 32'(acc), 32'd8);
    chk("t2_bank", bank, 32'h87654321);
    chk("t2_valid", 32'(bank_valid), 32'h1);

    // 3: three beats then abort, then refill
    start = 1; tick("t3_start");
    in_valid = 1;
    in_data = 4'hA; tick("t3_a");
    in_data = 4'hB; tick("t3_b");
    in_data = 4'hC; tick("t3_c");
    in_valid = 0;
    abort = 1; tick("t3_abort");
    chk("t3_low12", 32'(bank[11:0]), 32'hCBA);
    chk("t3_valid", 32'(bank_valid), 32'h0);
    chk("t3_ready", 32'(in_ready), 32'h0);
    start = 1; tick("t3_restart");
    chk("t3_ptr", 32'(fill_ptr), 32'h0);
    in_valid = 1; in_data = 4'h9; abort = 1; tick("t3_beat_abort");
    chk("t3_slot0", 32'(bank[3:0]), 32'h9);
    start = 1; in_valid = 0; tick("t3_start2");
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'($urandom); tick("t3_fill");
    end
    in_valid = 0;

    // 4: patch in FULL, then rejected patch in FILL
    wr_en = 1; wr_addr = 3'd5; wr_data = 4'hF; tick("t4_patch");
    chk("t4_slot5", 32'(bank[23:20]), 32'hF);
    chk("t4_valid", 32'(bank_valid), 32'h1);
    start = 1; tick("t4_start");
    wr_en = 1; wr_addr = 3'd5; wr_data = 4'h0; tick("t4_reject");
    chk("t4_err", 32'(wr_err), 32'h1);
    chk("t4_slot5_kept", 32'(bank[23:20]), 32'hF);
    tick("t4_err_clear");

    // 5: async reset after four beats
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = 4'($urandom | 1); tick("t5_beat");
    end
    #2;
    reset = 1;
    model_reset();
    #1;
    chk("t5_bank_zero", bank, 32'h0);
    compare_all("t5_async");
    @(posedge sysclk); #1;
    reset = 0; in_valid = 0;
    compare_all("t5_release");

    // 6: start during FILL is ignored
    start = 1; tick("t6_start");
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'($urandom);
      if (i == 3) start = 1;
      tick("t6_beat");
      if (i == 3) chk("t6_ptr", 32'(fill_ptr), 32'h4);
    end
    in_valid = 0;

    // patch together with start from FULL
    wr_en = 1; wr_addr = 3'd2; wr_data = 4'h7; start = 1; tick("t7_patch_start");
    chk("t7_slot2", 32'(bank[11:8]), 32'h7);
    chk("t7_ready", 32'(in_ready), 32'h1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      d        = 4'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      abort    = ($urandom_range(0, 23) == 0);
      wr_en    = ($urandom_range(0, 5) == 0);
      wr_addr  = 3'($urandom);
      wr_data  = 4'($urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = d;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_bank_loader.md
Name: nibble_bank_loader

Overview:
- Writer-side counterpart of the eight-operand selector datapath.
- Accepts a stream of 4-bit operands over a valid/ready handshake and fills an 8-entry nibble bank.
- Presents the bank as a flat bus whose slices drive the selector's I0..I7 operand inputs; exposes a random-access patch port and a bank-valid flag.
- Sits between the operand source (switch/UART front end) and the selector/result datapath.

Parameters:
NIBBLE_W, 4, width of each bank entry
DEPTH, 8, number of entries (bus slice k drives Ik); address width is fixed at 3

Ports:
sysclk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse; begins a sequential fill at slot 0
abort  input  1  single-cycle pulse; cancels an in-progress fill
in_valid  input  1  stream nibble valid
in_data  input  NIBBLE_W  stream nibble
in_ready  output  1  loader accepts a stream nibble this cycle
wr_en  input  1  random-access patch write strobe
wr_addr  input  3  patch slot index
wr_data  input  NIBBLE_W  patch value
wr_err  output  1  one-cycle pulse: patch write rejected
bank  output  DEPTH*NIBBLE_W  flat bank; bank[k*NIBBLE_W +: NIBBLE_W] = slot k
bank_valid  output  1  all DEPTH slots written since last start
fill_ptr  output  3  next slot to be filled
checksum  output  NIBBLE_W  see Optional Feature

Behaviour:
- Reset (async, immediate):
  - all bank slots 0; state IDLE; fill_ptr 0
  - in_ready 0, bank_valid 0, wr_err 0, checksum 0
- States: IDLE, FILL, FULL.
- in_ready is combinational: 1 exactly when state == FILL.
- A beat is accepted on a rising edge where in_valid && in_ready.
- IDLE:
  - start -> FILL, fill_ptr <= 0, bank_valid <= 0; bank contents are kept.
  - abort is ignored.
- FILL:
  - Each accepted beat writes bank[fill_ptr] <= in_data, visible on bank the next cycle.
  - After each beat, fill_ptr increments.
  - The beat that writes slot DEPTH-1 moves the state to FULL, sets bank_valid <= 1, and returns fill_ptr to 0 (wrap).
  - start is ignored.
  - abort -> IDLE: fill_ptr <= 0, bank_valid stays 0, slots already written keep their new values. A beat accepted in the same cycle as abort is still written.
  - in_valid with in_ready low: nothing is written and no state changes.
- FULL:
  - bank_valid stays 1 and in_ready stays 0.
  - start -> FILL (restart, as from IDLE).
  - abort -> IDLE with bank_valid <= 0.
- Patch port:
  - wr_en in IDLE or FULL writes bank[wr_addr] <= wr_data the next edge. bank_valid is unchanged.
  - wr_en in FILL is dropped and wr_err pulses high for one cycle. The bank is unchanged by the patch.
  - wr_en in the same cycle as start from IDLE/FULL: the patch is applied, then the state moves to FILL.
- All outputs are registered except in_ready.
- Latency: one cycle from an accepted beat or patch to the bank update.
- No combinational path exists from in_valid to in_ready.

Optional Feature:
- Macro: NIBBLE_BANK_CHECKSUM_EN.
- Defined:
  - checksum is a register holding the modulo-2^NIBBLE_W sum of all DEPTH slots.
  - It updates one cycle after any bank write (stream beat or patch).
  - It is cleared by reset only.
- Undefined: checksum is tied to 0 and no adder logic exists.

Test Plan:
1. Reset, pulse start, stream 1,2,3,4,5,6,7,8 with in_valid held high:
   - bank = 32'h87654321 one cycle after the 8th beat
   - bank_valid rises on that same cycle; in_ready drops; fill_ptr = 0
   - with NIBBLE_BANK_CHECKSUM_EN: checksum = 4'h4 (36 mod 16)
2. Stream with in_valid toggled every other cycle:
   - exactly 8 accepted beats
   - no writes on cycles where in_valid is low
   - final bank identical to test 1
3. Start, send 3 beats (A,B,C), pulse abort:
   - state IDLE, bank_valid 0, bank low 12 bits = 12'hCBA
   - a new start refills from slot 0
4. In FULL, patch wr_addr=5, wr_data=4'hF:
   - bank slice 5 becomes F; bank_valid stays 1
   - the same patch issued during FILL produces a wr_err pulse and no change
5. Assert reset mid-fill after 4 beats:
   - bank = 0, in_ready 0, bank_valid 0 immediately, without waiting for a clock edge
6. start pulsed during FILL:
   - ignored; fill_ptr continues uninterrupted
